// File: rtl/am_ask_envelope.sv
// am_ask_envelope
// AM/ASK envelope demodulator. Accepted samples are rectified (|x| or x*x
// scaled back to IN_W bits), averaged over a 2^AVG_LOG2 boxcar, decimated
// by DEC and sliced into an ASK bit with hysteresis.
//
// Ports:
//   clk, rst        sample clock (rising edge), async active-high reset
//   d_in, in_valid  signed input sample and its qualifier
//   mode            0 = absolute value, 1 = scaled square
//   clear           synchronous flush request
//   thr_hi, thr_lo  slicer set / clear thresholds (unsigned, thr_lo < thr_hi)
//   env_out         envelope (unsigned), held between emits
//   env_valid       one-cycle strobe qualifying env_out
//   bit_out         sliced ASK bit
//   filled          high while the averager window is full (RUN)
//
// Pipeline: edge 1 rectifies, edge 2 updates the running sum / FSM,
// edge 3 registers the outputs, so results appear three cycles after the
// sample was presented.
module am_ask_envelope #(
  parameter int IN_W     = 8,
  parameter int AVG_LOG2 = 4,
  parameter int DEC      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [IN_W-1:0] d_in,
  input  logic                   in_valid,
  input  logic                   mode,
  input  logic                   clear,
  input  logic        [IN_W-1:0] thr_hi,
  input  logic        [IN_W-1:0] thr_lo,
  output logic        [IN_W-1:0] env_out,
  output logic                   env_valid,
  output logic                   bit_out,
  output logic                   filled
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int SW = IN_W + AVG_LOG2;
  localparam logic [7:0]          DEC_M1   = 8'(DEC - 1);
  localparam logic [AVG_LOG2-1:0] FILL_END = AVG_LOG2'(N - 1);

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  // Both modes map the full signed range onto 0..2^(IN_W-1).
  function automatic logic [IN_W-1:0] rectify(input logic signed [IN_W-1:0] x,
                                              input logic sq);
    logic [IN_W-1:0]   ux;
    logic [IN_W-1:0]   mag;
    logic [2*IN_W-2:0] p;
    ux  = x;
    mag = ux[IN_W-1] ? (IN_W'(0) - ux) : ux;
    p   = (2*IN_W-1)'(mag) * (2*IN_W-1)'(mag);
    if (sq) return IN_W'(p >> (IN_W - 1));
    else    return mag;
  endfunction

  logic                mode_q;
  logic                flush;
  logic                v1;
  logic [IN_W-1:0]     r1;
  logic [IN_W-1:0]     buf_mem [N];
  logic [AVG_LOG2-1:0] wp;
  logic [AVG_LOG2-1:0] fill_cnt;
  logic [7:0]          dec_cnt;
  logic [SW-1:0]       sum;
  logic [SW-1:0]       sum_next;
  logic [IN_W-1:0]     oldest;
  logic [IN_W-1:0]     avg;
  logic                emit;
  state_t              state;

  // A mode change invalidates everything already averaged.
  assign flush  = clear | (mode != mode_q);
  assign oldest = buf_mem[wp];
  assign avg    = IN_W'(sum >> AVG_LOG2);

  // In RUN the oldest entry leaves the window as the new one enters.
  always_comb begin
    sum_next = sum + SW'(r1);
    if (state == RUN) sum_next = sum_next - SW'(oldest);
    else              sum_next = sum_next;
  end

  // Stage 1: rectify accepted samples; a flush drops the one in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
      v1     <= 1'b0;
      r1     <= '0;
    end else begin
      mode_q <= mode;
      v1     <= in_valid & ~flush;
      if (in_valid && !flush) r1 <= rectify(d_in, mode_q);
    end
  end

  // Window storage; never cleared, FILL overwrites it before it is read.
  always_ff @(posedge clk) begin
    if (v1 && !flush) buf_mem[wp] <= r1;
  end

  // Stage 2: running sum, fill/run FSM and decimation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      sum      <= '0;
      wp       <= '0;
      fill_cnt <= '0;
      dec_cnt  <= 8'd0;
      emit     <= 1'b0;
    end else if (flush) begin
      state    <= FILL;
      sum      <= '0;
      wp       <= '0;
      fill_cnt <= '0;
      dec_cnt  <= 8'd0;
      emit     <= 1'b0;
    end else begin
      emit <= 1'b0;
      if (v1) begin
        sum <= sum_next;
        wp  <= wp + AVG_LOG2'(1);
        case (state)
          FILL: begin
            fill_cnt <= fill_cnt + AVG_LOG2'(1);
            if (fill_cnt == FILL_END) begin
              state   <= RUN;
              emit    <= 1'b1;
              dec_cnt <= DEC_M1;
            end
          end
          RUN: begin
            if (dec_cnt == 8'd0) begin
              emit    <= 1'b1;
              dec_cnt <= DEC_M1;
            end else begin
              dec_cnt <= dec_cnt - 8'd1;
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

  // Stage 3: registered outputs and hysteresis slicer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      env_out   <= '0;
      env_valid <= 1'b0;
      bit_out   <= 1'b0;
      filled    <= 1'b0;
    end else begin
      env_valid <= emit;
      filled    <= (state == RUN);
      if (emit) begin
        env_out <= avg;
        if (avg >= thr_hi)      bit_out <= 1'b1;
        else if (avg <= thr_lo) bit_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_am_ask_envelope.sv
module tb_am_ask_envelope;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] d_in;
  logic              in_valid;
  logic              mode;
  logic              clear;
  logic [7:0]        thr_hi;
  logic [7:0]        thr_lo;
  logic [7:0]        env_out1, env_out4;
  logic              env_valid1, env_valid4;
  logic              bit_out1, bit_out4;
  logic              filled1, filled4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  am_ask_envelope #(.IN_W(8), .AVG_LOG2(4), .DEC(1)) dut1 (
    .clk(clk), .rst(rst), .d_in(d_in), .in_valid(in_valid), .mode(mode),
    .clear(clear), .thr_hi(thr_hi), .thr_lo(thr_lo), .env_out(env_out1),
    .env_valid(env_valid1), .bit_out(bit_out1), .filled(filled1));

  am_ask_envelope #(.IN_W(8), .AVG_LOG2(4), .DEC(4)) dut4 (
    .clk(clk), .rst(rst), .d_in(d_in), .in_valid(in_valid), .mode(mode),
    .clear(clear), .thr_hi(thr_hi), .thr_lo(thr_lo), .env_out(env_out4),
    .env_valid(env_valid4), .bit_out(bit_out4), .filled(filled4));

  // Expectation attached to one input cycle: emit flags for both DUTs,
  // envelope value on emit, and whether RUN holds after that cycle's edge.
  typedef struct packed {
    logic       v1;
    logic       v4;
    logic [7:0] env;
    logic       fl;
  } exp_t;

  exp_t       p1, p2;
  logic [7:0] h_env1, h_env4;
  logic       h_bit1, h_bit4;

  int   hist [16];
  int   s;
  int   rise_j, fall_j;
  logic [7:0] rise_env, fall_env;
  logic seen_low, rise_seen, fall_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic slice(input logic [7:0] e, input logic prev);
    if (e >= thr_hi)      return 1'b1;
    else if (e <= thr_lo) return 1'b0;
    else                  return prev;
  endfunction

  task automatic reset_model();
    p1 = '0; p2 = '0;
    h_env1 = 8'd0; h_env4 = 8'd0;
    h_bit1 = 1'b0; h_bit4 = 1'b0;
  endtask

  // One clock: drive inputs, then compare outputs that belong to the
  // input presented two calls earlier (three-cycle latency).
  task automatic cyc(input logic clr, input logic v, input logic signed [7:0] d,
                     input logic e1, input logic e4, input logic [7:0] ee, input logic fl);
    exp_t cur;
    cur.v1 = e1; cur.v4 = e4; cur.env = ee; cur.fl = fl;
    clear = clr; in_valid = v; d_in = d;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    if (p2.v1) begin h_env1 = p2.env; h_bit1 = slice(p2.env, h_bit1); end
    if (p2.v4) begin h_env4 = p2.env; h_bit4 = slice(p2.env, h_bit4); end
    check("env_valid1", env_valid1, p2.v1);
    check("env_out1",   env_out1,   h_env1);
    check("bit_out1",   bit_out1,   h_bit1);
    check("filled1",    filled1,    p1.fl);
    check("env_valid4", env_valid4, p2.v4);
    check("env_out4",   env_out4,   h_env4);
    check("bit_out4",   bit_out4,   h_bit4);
    check("filled4",    filled4,    p1.fl);
    p2 = p1; p1 = cur;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'sd0, 1'b0, 1'b0, 8'd0, 1'b1);
  endtask

  task automatic flush_cycle();
    cyc(1'b1, 1'b0, 8'sd0, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  // n back-to-back samples starting from an empty window; kill_last marks a
  // final sample whose update is pre-empted by a flush on the next cycle.
  task automatic stream(input int n, input logic signed [7:0] a, input logic alt,
                        input logic [7:0] ee, input logic kill_last);
    logic signed [7:0] d;
    logic e1, e4;
    for (int j = 1; j <= n; j++) begin
      d  = (alt && (j % 2 == 0)) ? -a : a;
      e1 = (j >= 16) && !(kill_last && (j == n));
      e4 = e1 && ((j - 16) % 4 == 0);
      cyc(1'b0, 1'b1, d, e1, e4, ee, j >= 17);
    end
  endtask

  initial begin
    rst = 1'b1; d_in = 8'sd0; in_valid = 1'b0; mode = 1'b0; clear = 1'b0;
    thr_hi = 8'd60; thr_lo = 8'd30;
    reset_model();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_env_out1",   env_out1,   8'd0);
    check("rst_env_valid1", env_valid1, 1'b0);
    check("rst_bit_out1",   bit_out1,   1'b0);
    check("rst_filled1",    filled1,    1'b0);
    check("rst_env_out4",   env_out4,   8'd0);
    check("rst_filled4",    filled4,    1'b0);
    rst = 1'b0;

    // Constant +64, abs mode.
    stream(20, 8'sd64, 1'b0, 8'd64, 1'b0);
    idle(2);
    // Alternating +/-64.
    flush_cycle();
    stream(20, 8'sd64, 1'b1, 8'd64, 1'b0);
    idle(2);
    // -128 in abs mode.
    flush_cycle();
    stream(20, -8'sd128, 1'b0, 8'd128, 1'b0);
    idle(2);
    // -128 in square mode.
    mode = 1'b1;
    flush_cycle();
    stream(20, -8'sd128, 1'b0, 8'd128, 1'b0);
    idle(2);
    // +64 in square mode, then toggle mode mid-stream.
    flush_cycle();
    stream(20, 8'sd64, 1'b0, 8'd32, 1'b1);
    mode = 1'b0;
    cyc(1'b0, 1'b1, 8'sd64, 1'b0, 1'b0, 8'd0, 1'b0);
    stream(20, 8'sd64, 1'b0, 8'd64, 1'b0);
    idle(2);
    // Decimation with clear: the -128 on the clear cycle must be dropped.
    flush_cycle();
    stream(20, 8'sd64, 1'b0, 8'd64, 1'b1);
    cyc(1'b1, 1'b1, -8'sd128, 1'b0, 1'b0, 8'd0, 1'b0);
    stream(26, 8'sd64, 1'b0, 8'd64, 1'b0);
    idle(2);

    // ASK slicer: 32 zeros, 32 alternating +/-100, 32 zeros.
    flush_cycle();
    for (int i = 0; i < 16; i++) hist[i] = 0;
    rise_j = 0; fall_j = 0; rise_env = 8'd0; fall_env = 8'd0;
    seen_low = 1'b0; rise_seen = 1'b0; fall_seen = 1'b0;
    for (int j = 1; j <= 96; j++) begin
      logic signed [7:0] d;
      int val;
      logic e1;
      val = (j >= 33 && j <= 64) ? 100 : 0;
      d   = (j % 2 == 0) ? -8'(val) : 8'(val);
      hist[(j - 1) % 16] = val;
      s = 0;
      for (int k = 0; k < 16; k++) s += hist[k];
      e1 = (j >= 16);
      cyc(1'b0, 1'b1, d, e1, e1 && ((j - 16) % 4 == 0), 8'(s / 16), j >= 17);
      if (!bit_out1) seen_low = 1'b1;
      if (seen_low && !rise_seen && bit_out1) begin
        rise_seen = 1'b1; rise_j = j - 2; rise_env = env_out1;
      end
      if (rise_seen && !fall_seen && !bit_out1) begin
        fall_seen = 1'b1; fall_j = j - 2; fall_env = env_out1;
      end
    end
    idle(2);
    check("ask_rise_sample", rise_j, 42);
    check("ask_rise_env",    rise_env, 8'd62);
    check("ask_fall_sample", fall_j, 76);
    check("ask_fall_env",    fall_env, 8'd25);

    // Asynchronous reset in the middle of a burst.
    flush_cycle();
    stream(24, 8'sd100, 1'b1, 8'd100, 1'b0);
    check("pre_rst_bit1",    bit_out1, 1'b1);
    check("pre_rst_filled1", filled1,  1'b1);
    in_valid = 1'b1; d_in = 8'sd100;
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_bit1",    bit_out1,   1'b0);
    check("async_rst_filled1", filled1,    1'b0);
    check("async_rst_env1",    env_out1,   8'd0);
    check("async_rst_valid1",  env_valid1, 1'b0);
    check("async_rst_bit4",    bit_out4,   1'b0);
    check("async_rst_filled4", filled4,    1'b0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    reset_model();
    // Refill after reset.
    stream(20, 8'sd64, 1'b0, 8'd64, 1'b0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/am_ask_envelope.md
# am_ask_envelope

Parametrised AM/ASK envelope demodulator: rectifies a signed sample stream (absolute value or scaled square, run-time selectable), low-passes it with a power-of-two boxcar moving average, decimates, and slices the envelope into an ASK bit with hysteresis. It sits after the ADC sample path in the demodulation chain. It replaces fixed-width, free-running rectify+FIR envelope paths, adding valid qualification, flush/fill control and a bit slicer.

## Interface
- IN_W, 8: input sample width (signed); also the width of the envelope and thresholds (unsigned).
- AVG_LOG2, 4: log2 of the moving-average depth N = 2^AVG_LOG2 (1..8).
- DEC, 1: decimation ratio for env_valid (1..255).

- clk  in  1  sample clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- d_in  in  IN_W  signed input sample.
- in_valid  in  1  d_in is valid this cycle.
- mode  in  1  0 = absolute value, 1 = scaled square.
- clear  in  1  synchronous flush request.
- thr_hi  in  IN_W  slicer set threshold (unsigned).
- thr_lo  in  IN_W  slicer clear threshold (unsigned); thr_lo < thr_hi is required.
- env_out  out  IN_W  envelope, unsigned.
- env_valid  out  1  one-cycle strobe qualifying env_out.
- bit_out  out  1  sliced ASK bit.
- filled  out  1  high while in RUN state.

## Operation
- Rectify (registered, stage 1) on accepted samples:
  - mode 0: r = |d_in|.
  - mode 1: r = (d_in*d_in) >> (IN_W-1).
  - Both give the range 0..2^(IN_W-1), held in IN_W bits unsigned. Example: -128 gives 128 in both modes.
- Averager (stage 2):
  - Circular buffer of N entries × IN_W bits with write pointer wp (AVG_LOG2 bits, wraps N-1 to 0).
  - Running sum of IN_W+AVG_LOG2 bits, which cannot overflow.
  - Each stage-1 valid: buf[wp] <= r, wp <= wp+1.
- FSM states FILL and RUN; reset state is FILL.
  - FILL: sum <= sum + r, with no subtraction. A fill counter counts writes. On the write that makes the count N, go to RUN and emit the first env_valid.
  - RUN: sum <= sum + r − buf[wp], where buf[wp] is the oldest entry, read before the overwrite.
- Flush, caused by clear = 1 or by mode differing from the registered mode_q:
  - Next edge: state to FILL; sum, wp, fill count and decimation counter to 0.
  - Stage-1 valid is cleared; a sample accepted on the flush cycle is discarded.
  - mode_q <= mode.
  - Buffer contents are not cleared; FILL overwrites them before they are read.
- Decimation:
  - The first RUN output is emitted.
  - After each emit the counter loads DEC-1. It decrements on each later RUN update; when it is 0, the next RUN update emits.
  - DEC = 1 emits on every update.
- Output on emit: env_out <= sum_next >> AVG_LOG2, where sum_next is the sum after that edge's update.
- Slicer, evaluated only on emit with e = the new env_out value:
  - e >= thr_hi sets bit_out to 1.
  - e <= thr_lo clears bit_out to 0.
  - Otherwise bit_out holds.
- Reset values: env_out = 0, env_valid = 0, bit_out = 0, filled = 0; sum, wp and counters 0; mode_q = 0.

## Timing
- Latency: in_valid in cycle c gives the corresponding env_valid/env_out/bit_out in cycle c+3, with updates on the edges ending c, c+1 and c+2.
- env_valid is high for exactly one cycle per emit.
- env_out and bit_out hold between emits.
- Full throughput: one sample per cycle; back-to-back in_valid is legal.
- filled rises the cycle after the edge that enters RUN, coincident with the first env_valid.
- First output after reset or flush: the N-th accepted sample produces it, at c+3 of that sample.
- Flush and the stage-2 update on the same edge: flush wins, and the pending sample does not update the sum.
- Asynchronous reset mid-stream: all state clears immediately and FILL restarts.
- Thresholds are sampled on the emit edge; changes take effect at the next emit.

## Test plan
- Constant, abs mode: IN_W=8, AVG_LOG2=4, DEC=1, mode 0, d_in = +64 for 20 cycles -> no env_valid for samples 1–15; env_valid at c+3 of sample 16 with env_out = 64, then 64 every cycle.
- Sign and extremes: alternating ±64 -> env_out 64; constant −128 in mode 0 and in mode 1 -> env_out 128 in both.
- Square mode: constant +64, mode 1 -> env_out = 32 after fill.
- Mode toggle mid-stream: toggling mode during RUN -> filled drops, no env_valid for the next 15 samples, the 16th emits with the new-mode value.
- Decimation with clear: DEC = 4 -> emits on samples 16, 20, 24…; asserting clear with in_valid on the same cycle discards that sample and refills.
- ASK slicer: thr_hi = 60, thr_lo = 30, DEC = 1, 32 zero samples, then 32 of alternating ±100, then 32 zeros:
  - bit_out rises on the emit of the 10th on-sample (env 62).
  - bit_out falls on the emit of the 12th off-sample (env 25).
  - rst pulse mid-burst -> bit_out = 0 and filled = 0 immediately.
